// File: rtl/lms_plant_source.sv
// lms_plant_source: LFSR/external stimulus through a loadable FIR plant H(z), emitting aligned (x, d) pairs; LMS_PLANT_NOISE_EN adds measurement noise to d
module lms_plant_source #(
   parameter int          DATA_WIDTH     = 32,
   parameter int          FILTER_ORDER   = 5,
   parameter int          COEF_FRAC_BITS = 8,
   parameter int          X_BITS         = 12,
   parameter logic [31:0] LFSR_SEED      = 32'h1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              coef_wr_en,
   input  logic [$clog2(FILTER_ORDER)-1:0]   coef_wr_addr,
   input  logic signed [DATA_WIDTH-1:0]      coef_wr_data,
   input  logic                              start,
   input  logic                              stop,
   input  logic [15:0]                       run_len,
   input  logic                              ext_x_en,
   input  logic signed [DATA_WIDTH-1:0]      x_ext,
   input  logic                              out_ready,
   output logic                              out_valid,
   output logic signed [DATA_WIDTH-1:0]      x_out,
   output logic signed [DATA_WIDTH-1:0]      d_out,
   output logic                              busy,
   output logic                              done,
   output logic [15:0]                       sample_cnt
);
   localparam int PW = 2 * DATA_WIDTH;
   localparam logic [31:0] POLY = 32'h80200003;
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   function automatic logic [31:0] step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? POLY : 32'h0);
   endfunction
   state_t state_q, state_d;
   logic signed [DATA_WIDTH-1:0] coef_q [FILTER_ORDER];
   logic signed [DATA_WIDTH-1:0] coef_d [FILTER_ORDER];
   logic signed [DATA_WIDTH-1:0] tap_q [FILTER_ORDER];
   logic signed [DATA_WIDTH-1:0] tap_d [FILTER_ORDER];
   logic signed [DATA_WIDTH-1:0] p_q [FILTER_ORDER];
   logic signed [DATA_WIDTH-1:0] p_d [FILTER_ORDER];
   logic signed [DATA_WIDTH-1:0] s1_x_q, s1_x_d, x_out_q, x_out_d, d_out_q, d_out_d, x_new, sum;
   logic tap_v_q, tap_v_d, s1_v_q, s1_v_d, out_valid_q, out_valid_d;
   logic busy_q, busy_d, done_q, done_d, ext_q, ext_d, flush_q, flush_d, adv, inject;
   logic [15:0] cnt_q, cnt_d, len_q, len_d;
   logic [31:0] lfsr_q, lfsr_d, lfsr_nx;
`ifdef LMS_PLANT_NOISE_EN
   logic [31:0] noise_q, noise_d;
`endif
   always_comb begin
      adv = out_ready | ~out_valid_q;
      inject = state_q == RUN && adv && !stop;
      lfsr_nx = step(lfsr_q);
      x_new = ext_q ? x_ext : {{(DATA_WIDTH-X_BITS){lfsr_nx[X_BITS-1]}}, lfsr_nx[X_BITS-1:0]};
      state_d = state_q;
      coef_d = coef_q;
      tap_d = tap_q;
      tap_v_d = adv ? inject : tap_v_q;
      lfsr_d = inject && !ext_q ? lfsr_nx : lfsr_q;
      busy_d = busy_q;
      done_d = 1'b0;
      ext_d = ext_q;
      len_d = len_q;
      cnt_d = cnt_q;
      flush_d = flush_q;
      if (inject) begin
         tap_d[0] = x_new;
         for (int i = 1; i < FILTER_ORDER; i++) tap_d[i] = tap_q[i-1];
         cnt_d = cnt_q + 16'd1;
      end
      if (state_q == IDLE) begin
         if (coef_wr_en && int'(coef_wr_addr) < FILTER_ORDER) coef_d[coef_wr_addr] = coef_wr_data;
         if (start) begin
            state_d = RUN;
            busy_d = 1'b1;
            len_d = run_len;
            ext_d = ext_x_en;
            cnt_d = '0;
         end
      end else if (state_q == RUN) begin
         if (stop || (inject && len_q != 16'd0 && cnt_d == len_q)) begin
            state_d = FLUSH;
            flush_d = 1'b0;
         end
      end else if (adv) begin
         // second flush advance puts the last pair on the outputs
         flush_d = 1'b1;
         if (flush_q) begin
            state_d = IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
      // products are truncated before summing; the sum wraps identically either way
      for (int i = 0; i < FILTER_ORDER; i++)
         p_d[i] = adv ? DATA_WIDTH'((PW'(tap_q[i]) * PW'(coef_q[i])) >>> COEF_FRAC_BITS) : p_q[i];
      s1_x_d = adv ? tap_q[0] : s1_x_q;
      s1_v_d = adv ? tap_v_q : s1_v_q;
      sum = '0;
      for (int i = 0; i < FILTER_ORDER; i++) sum = sum + p_q[i];
`ifdef LMS_PLANT_NOISE_EN
      noise_d = adv ? step(noise_q) : noise_q;
      sum = sum + {{(DATA_WIDTH-4){noise_d[3]}}, noise_d[3:0]};
`endif
      x_out_d = adv ? s1_x_q : x_out_q;
      d_out_d = adv ? sum : d_out_q;
      out_valid_d = adv ? s1_v_q : out_valid_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         coef_q <= '{default: '0};
         tap_q <= '{default: '0};
         p_q <= '{default: '0};
         tap_v_q <= 1'b0;
         s1_x_q <= '0;
         s1_v_q <= 1'b0;
         x_out_q <= '0;
         d_out_q <= '0;
         out_valid_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         ext_q <= 1'b0;
         len_q <= '0;
         cnt_q <= '0;
         flush_q <= 1'b0;
         lfsr_q <= LFSR_SEED;
`ifdef LMS_PLANT_NOISE_EN
         noise_q <= 32'hACE1;
`endif
      end else begin
         state_q <= state_d;
         coef_q <= coef_d;
         tap_q <= tap_d;
         p_q <= p_d;
         tap_v_q <= tap_v_d;
         s1_x_q <= s1_x_d;
         s1_v_q <= s1_v_d;
         x_out_q <= x_out_d;
         d_out_q <= d_out_d;
         out_valid_q <= out_valid_d;
         busy_q <= busy_d;
         done_q <= done_d;
         ext_q <= ext_d;
         len_q <= len_d;
         cnt_q <= cnt_d;
         flush_q <= flush_d;
         lfsr_q <= lfsr_d;
`ifdef LMS_PLANT_NOISE_EN
         noise_q <= noise_d;
`endif
      end
   end
   assign out_valid = out_valid_q;
   assign x_out = x_out_q;
   assign d_out = d_out_q;
   assign busy = busy_q;
   assign done = done_q;
   assign sample_cnt = cnt_q;
endmodule

// File: tb/tb_lms_plant_source.sv
// tb_lms_plant_source: randomized runs of lms_plant_source checked against a transaction-level plant model
module tb_lms_plant_source;
   typedef struct packed {logic [31:0] x; logic [31:0] d;} pair_t;
   logic clk = 0, reset = 1, coef_wr_en = 0, start = 0, stop = 0, ext_x_en = 0, out_ready = 1;
   logic [2:0] coef_wr_addr = 0;
   logic [31:0] coef_wr_data = 0, x_ext;
   logic [15:0] run_len = 0, sample_cnt;
   logic out_valid, busy, done;
   logic [31:0] x_out, d_out;
   int xtab [64];
   int checks = 0, fails = 0, rdy_mode = 0, bp_cnt = 0, noise_seen = 0;
   bit chk_en = 0, prev_hold = 0;
   logic [31:0] prev_x, prev_d;
   pair_t exp_q [$], last_exp [$], cmp_e;
   int m_coef [5], m_tap [5];
   logic [31:0] m_lfsr = 32'h1;

   lms_plant_source dut (
      .clk(clk), .reset(reset), .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr),
      .coef_wr_data(coef_wr_data), .start(start), .stop(stop), .run_len(run_len),
      .ext_x_en(ext_x_en), .x_ext(x_ext), .out_ready(out_ready), .out_valid(out_valid),
      .x_out(x_out), .d_out(d_out), .busy(busy), .done(done), .sample_cnt(sample_cnt)
   );

   always #5 clk = ~clk;
   assign x_ext = xtab[sample_cnt[5:0]];

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", nm, $signed(act), $signed(req));
      end
   endfunction

   function automatic logic [31:0] m_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 5; i++) begin m_coef[i] = 0; m_tap[i] = 0; end
      m_lfsr = 32'h1;
      exp_q.delete();
   endtask

   task automatic m_push(input int x);
      longint acc;
      pair_t p;
      acc = 0;
      for (int i = 4; i > 0; i--) m_tap[i] = m_tap[i-1];
      m_tap[0] = x;
      for (int i = 0; i < 5; i++) acc += (longint'(m_tap[i]) * longint'(m_coef[i])) >>> 8;
      p.x = x;
      p.d = acc[31:0];
      exp_q.push_back(p);
      last_exp.push_back(p);
   endtask

   task automatic wr(input int addr, input int data);
      coef_wr_en = 1; coef_wr_addr = 3'(addr); coef_wr_data = data;
      @(posedge clk); #1;
      coef_wr_en = 0;
      if (addr < 5) m_coef[addr] = data;
   endtask

   task automatic do_run(input int len, input bit ext, input int stop_after,
                         input bit s_wr, input int s_addr, input int s_data, input bit mid_wr);
      int n, cyc, x;
      n = (stop_after > 0) ? stop_after : len;
      if (s_wr && s_addr < 5) m_coef[s_addr] = s_data;
      last_exp.delete();
      for (int k = 0; k < n; k++) begin
         if (ext) x = xtab[k];
         else begin
            m_lfsr = m_step(m_lfsr);
            x = {{20{m_lfsr[11]}}, m_lfsr[11:0]};
         end
         m_push(x);
      end
      start = 1; run_len = 16'(len); ext_x_en = ext;
      coef_wr_en = s_wr; coef_wr_addr = 3'(s_addr); coef_wr_data = s_data;
      @(posedge clk); #1;
      start = 0; coef_wr_en = mid_wr; coef_wr_addr = 3'd1; coef_wr_data = 1000;
      chk("busy_run", {31'd0, busy}, 1);
      cyc = 0;
      while (!done && cyc < 3000) begin
         if (stop_after > 0 && sample_cnt == 16'(stop_after)) stop = 1;
         @(posedge clk); #1;
         coef_wr_en = 0;
         cyc++;
      end
      chk("done_seen", {31'd0, done}, 1);
      if (rdy_mode == 0 && stop_after == 0) chk("done_latency", cyc, len + 2);
      chk("cnt_end", {16'd0, sample_cnt}, n);
      chk("busy_end", {31'd0, busy}, 0);
      stop = 0;
      @(posedge clk); #1;
      chk("done_pulse", {31'd0, done}, 0);
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 500) begin @(posedge clk); #1; cyc++; end
      chk("drained", exp_q.size(), 0);
   endtask

   initial forever begin
      @(posedge clk); #1;
      bp_cnt++;
      out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom % 4 != 0) : !(bp_cnt >= 4 && bp_cnt <= 6);
   end

   initial forever begin
      @(negedge clk);
      if (reset || !chk_en) prev_hold = 0;
      else begin
         if (prev_hold) begin
            chk("hold_valid", {31'd0, out_valid}, 1);
            chk("hold_x", x_out, prev_x);
            chk("hold_d", d_out, prev_d);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_pair", 1, 0);
            else begin
               cmp_e = exp_q.pop_front();
               chk("x_out", x_out, cmp_e.x);
`ifdef LMS_PLANT_NOISE_EN
               begin
                  int diff;
                  diff = int'(d_out - cmp_e.d);
                  if (diff != 0) noise_seen++;
                  chk("d_noise_bound", {31'd0, diff >= -8 && diff <= 8}, 1);
               end
`else
               chk("d_out", d_out, cmp_e.d);
`endif
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_x = x_out;
         prev_d = d_out;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int imp_d [5] = '{100, 50, -25, 0, 12};
      bit seen;
      int len, sa;
      bit ext;
      for (int i = 0; i < 64; i++) xtab[i] = 0;
      xtab[0] = 100;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, out_valid}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_x", x_out, 0);
      chk("rst_d", d_out, 0);
      chk("rst_cnt", {16'd0, sample_cnt}, 0);
      reset = 0;
      chk_en = 1;
      wr(0, 256); wr(1, 128); wr(2, -64); wr(3, 0); wr(4, 32);
      do_run(5, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) chk("imp_model_d", last_exp[k].d, imp_d[k]);
      rdy_mode = 2; bp_cnt = 0;
      do_run(5, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) chk("bp_model_d", last_exp[k].d, imp_d[k]);
      rdy_mode = 0;
      wr(1, 0); wr(2, 0); wr(3, 0); wr(7, 999);
      do_run(20, 0, 0, 1, 4, 0, 0);
      chk("id_first_x", last_exp[0].x, 3);
      for (int k = 0; k < 20; k++) chk("id_model", last_exp[k].d, last_exp[k].x);
      do_run(0, 0, 7, 0, 0, 0, 1);
      chk("stop_pairs", last_exp.size(), 7);
      rdy_mode = 1;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 5; i++) wr(i, int'($urandom));
         wr(5 + int'($urandom % 3), int'($urandom));
         for (int i = 0; i < 64; i++) xtab[i] = int'($urandom);
         ext = $urandom % 2;
         len = (r % 4 == 3) ? 0 : int'($urandom_range(1, 20));
         sa = (len == 0) ? int'($urandom_range(1, 10)) : 0;
         do_run(len, ext, sa, $urandom % 2, int'($urandom % 5), int'($urandom), $urandom % 2);
      end
      rdy_mode = 0;
      @(posedge clk); #1;
      chk_en = 0;
      start = 1; run_len = 0; ext_x_en = 0;
      @(posedge clk); #1;
      start = 0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1;
      @(posedge clk); #1;
      chk("midrst_valid", {31'd0, out_valid}, 0);
      chk("midrst_busy", {31'd0, busy}, 0);
      chk("midrst_cnt", {16'd0, sample_cnt}, 0);
      reset = 0;
      m_reset();
      seen = 0;
      repeat (6) begin
         if (done) seen = 1;
         @(posedge clk); #1;
      end
      chk("midrst_no_done", {31'd0, seen}, 0);
      chk_en = 1;
      for (int i = 0; i < 64; i++) xtab[i] = 0;
      xtab[0] = 100;
      do_run(5, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) chk("post_rst_model_d", last_exp[k].d, 0);
`ifdef LMS_PLANT_NOISE_EN
      chk("noise_nonzero", {31'd0, noise_seen > 0}, 1);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/lms_plant_source.md
Name: lms_plant_source

Overview:
- Stimulus and reference-plant block that drives the adaptive filter's inputs (x_in, d_in).
- Generates input samples x from an internal LFSR, or from an external port.
- Passes each x through a fixed, loadable FIR "unknown system" H(z).
- Emits x and the desired response d = H*x as an aligned pair, with a valid/ready handshake, for a programmed run length.

Parameters:
- DATA_WIDTH, 32, width of x_out, d_out, x_ext and coefficients (signed).
- FILTER_ORDER, 5, number of plant taps (>= 2).
- COEF_FRAC_BITS, 8, fractional bits of coefficients; each product is arithmetic-shifted right by this amount.
- X_BITS, 12, LFSR sample width; the sample is the sign-extended low X_BITS of the LFSR state.
- LFSR_SEED, 32'h1, LFSR reset value (must be nonzero).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- coef_wr_en  in  1  coefficient write strobe
- coef_wr_addr  in  $clog2(FILTER_ORDER)  tap index
- coef_wr_data  in  DATA_WIDTH  signed coefficient value
- start  in  1  begin a run (sampled in IDLE only)
- stop  in  1  abort the run and flush
- run_len  in  16  number of samples per run; 0 = free-running
- ext_x_en  in  1  1 = take x from x_ext instead of the LFSR (latched at start)
- x_ext  in  DATA_WIDTH  external sample
- out_ready  in  1  consumer accepts the current pair
- out_valid  out  1  x_out/d_out hold a valid pair
- x_out  out  DATA_WIDTH  plant input sample
- d_out  out  DATA_WIDTH  plant output sample
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on return to IDLE
- sample_cnt  out  16  samples generated in the current run

Behaviour:
- Reset (synchronous, active-high) clears:
  - state to IDLE and all coefficients to 0
  - tap shift register and pipeline registers to 0
  - LFSR to LFSR_SEED
  - out_valid, done, busy, x_out, d_out and sample_cnt to 0
- Reset overrides everything, including a run in progress; no done pulse is produced.
- advance = out_ready | ~out_valid. All pipeline stages, the tap shift and the LFSR step only when advance=1.
- When out_valid=1 and out_ready=0, x_out and d_out are held stable.
- States:
  - IDLE: coefficient writes are accepted (coef[addr] <= data; address >= FILTER_ORDER is ignored). start=1 latches run_len and ext_x_en, clears sample_cnt, and moves to RUN. start and a coef write in the same cycle: the write lands first, and the run uses the new value.
  - RUN: on each advance, one new sample enters tap 0, older taps shift by one, the LFSR steps once if selected, and sample_cnt increments. When sample_cnt reaches run_len (run_len != 0), or when stop=1, move to FLUSH; no new samples are injected after that. stop has priority over the count-reached condition in the same cycle.
  - FLUSH: zeros are not injected; the two pipeline stages drain over two advances, then the block moves to IDLE and pulses done. stop in FLUSH is ignored.
- Coefficient writes outside IDLE are ignored.
- start while not in IDLE is ignored.
- Pipeline (latency 2 advances from a sample entering tap 0 to its pair on the outputs):
  - S1: register p[i] = (tap[i]*coef[i]) >>> COEF_FRAC_BITS, computed at 2*DATA_WIDTH precision; also register x = tap[0] and a valid bit.
  - S2: d_out = sum of p[i] in 2*DATA_WIDTH precision, truncated (wraps) to DATA_WIDTH; x_out and out_valid are registered alongside.
- Tap contents persist across runs and are cleared only by reset. Taps are not zeroed between runs, so the first outputs of a run reflect the history of the previous run.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, shifted right, feedback mask 32'h80200003. The LFSR is not stepped while ext_x_en is latched.
- run_len=0: the block stays in RUN until stop; sample_cnt wraps at 2^16.

Optional Feature:
- Macro: LMS_PLANT_NOISE_EN.
- Defined:
  - Adds a second LFSR (seed 32'hACE1, same polynomial) that steps on every S2 advance.
  - Its sign-extended low 4 bits are added to d_out before the truncation to DATA_WIDTH, modelling measurement noise.
  - The noise LFSR is reset with the main LFSR.
- Undefined: no second LFSR; d_out is the exact FIR output.
- Latency and the handshake are identical in both builds.

Test Plan:
- Impulse response: coefs = [256,128,-64,0,32], ext_x_en=1, x_ext = 100 then 0, run_len=5, out_ready=1 → d_out = 100, 50, -25, 0, 12 on consecutive valid cycles; x_out = 100, 0, 0, 0, 0; done pulses 2 cycles after the 5th sample enters.
- Identity: coef = [256,0,0,0,0], LFSR source, run_len=20 → d_out == x_out for all 20 pairs; the first x_out is the sign-extended low 12 bits of the LFSR after one step from seed 1.
- Backpressure: during the impulse test, hold out_ready=0 for 3 cycles → outputs frozen, no sample lost or duplicated, and the sequence is unchanged.
- Stop and ignored writes: run_len=0, assert stop after 7 samples → exactly 7 valid pairs, then done, then IDLE. A coef write issued during RUN does not change subsequent d_out.
- Reset mid-run: assert reset during RUN → next cycle out_valid=0, busy=0, all coefs read 0 (a following impulse run gives d_out = 0), and no done pulse.
- LMS_PLANT_NOISE_EN defined, identity coefs → |d_out - x_out| <= 8 on every pair, and it is not identically 0 across 32 pairs.
